// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// The state enum and default width/depth match the mips_cpu build.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-side bus of regfile_mp: two write ports, scoreboard set,
// packed read ports and status outputs.
interface regfile_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_reg;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_reg;
  logic [DATA_W-1:0]        wb_data;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_reg;
  logic [NUM_RD*ADDR_W-1:0] rd_reg;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [DATA_W-1:0]        register_v0;
  logic                     ready;

  modport master (
    output wa_en, wa_reg, wa_data, wb_en, wb_reg, wb_data,
           busy_set, busy_reg, rd_reg,
    input  rd_data, rd_busy, register_v0, ready
  );

  modport slave (
    input  wa_en, wa_reg, wa_data, wb_en, wb_reg, wb_data,
           busy_set, busy_reg, rd_reg,
    output rd_data, rd_busy, register_v0, ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, bit 0 always clear.
// A set on the same register as a clear wins, since it marks a newer load.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic                        r_clk,
  input  logic                        reset,
  input  logic                        set_en,
  input  logic [$clog2(NUM_REGS)-1:0] set_reg,
  input  logic                        clr_en,
  input  logic [$clog2(NUM_REGS)-1:0] clr_reg,
  output logic [NUM_REGS-1:0]         busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // next busy vector: clear first so a concurrent set overrides it
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_reg] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (set_en) begin
      busy_d[set_reg] = 1'b1;
    end else begin
      busy_d[set_reg] = busy_d[set_reg];
    end
    busy_d[0] = 1'b0;
  end

  // busy bit storage
  always_ff @(posedge r_clk) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, pending-load
// scoreboard and a post-reset clear sweep of every register.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int V0_IDX   = 2,
  parameter int BYPASS   = 1
) (
  input  logic        r_clk,
  input  logic        reset,
  input  logic        r_clk_enable,
  regfile_mp_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic                out_en;
  logic                wr_ok;
  logic                a_eff;
  logic                b_hit;
  logic                b_eff;
  logic                set_en;
  logic [NUM_REGS-1:0] busy;

  logic [ADDR_W-1:0]        ra     [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]        rd_busy_s;

  // write qualification; b_hit still clears busy when port A wins the data
  always_comb begin
    out_en = (state_q == READY) && reset;
    wr_ok  = out_en && r_clk_enable;
    a_eff  = wr_ok && bus.wa_en && (bus.wa_reg != '0);
    b_hit  = wr_ok && bus.wb_en && (bus.wb_reg != '0);
    b_eff  = b_hit && !(a_eff && (bus.wa_reg == bus.wb_reg));
    set_en = wr_ok && bus.busy_set && (bus.busy_reg != '0);
  end

  // sweep sequencing: one register per cycle, then READY until reset
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = READY;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // state and sweep pointer
  always_ff @(posedge r_clk) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // next register contents: sweep clear, or writeback through both ports
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (reset && (state_q == CLEAR)) begin
      regs_d[ptr_q] = '0;
    end else begin
      if (b_eff) begin
        regs_d[bus.wb_reg] = bus.wb_data;
      end else begin
        regs_d[bus.wb_reg] = regs_d[bus.wb_reg];
      end
      if (a_eff) begin
        regs_d[bus.wa_reg] = bus.wa_data;
      end else begin
        regs_d[bus.wa_reg] = regs_d[bus.wa_reg];
      end
    end
  end

  // register storage; contents are initialised by the sweep, not by reset
  always_ff @(posedge r_clk) begin
    regs_q <= regs_d;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .r_clk   (r_clk),
    .reset   (reset),
    .set_en  (set_en),
    .set_reg (bus.busy_reg),
    .clr_en  (b_hit),
    .clr_reg (bus.wb_reg),
    .busy    (busy)
  );

  // read ports: zero register, bypass (A before B), then stored value
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i] = bus.rd_reg[i*ADDR_W +: ADDR_W];
      if (!out_en || (ra[i] == '0)) begin
        rd_data_s[i*DATA_W +: DATA_W] = '0;
        rd_busy_s[i]                  = 1'b0;
      end else begin
        if ((BYPASS != 0) && a_eff && (bus.wa_reg == ra[i])) begin
          rd_data_s[i*DATA_W +: DATA_W] = bus.wa_data;
        end else if ((BYPASS != 0) && b_eff && (bus.wb_reg == ra[i])) begin
          rd_data_s[i*DATA_W +: DATA_W] = bus.wb_data;
        end else begin
          rd_data_s[i*DATA_W +: DATA_W] = regs_q[ra[i]];
        end
        if ((BYPASS != 0) && b_hit && (bus.wb_reg == ra[i])) begin
          rd_busy_s[i] = 1'b0;
        end else begin
          rd_busy_s[i] = busy[ra[i]];
        end
      end
    end
  end

  assign bus.rd_data     = rd_data_s;
  assign bus.rd_busy     = rd_busy_s;
  assign bus.register_v0 = out_en ? regs_q[V0_IDX] : '0;
  assign bus.ready       = out_en;

endmodule
